// File: rtl/counter_pkg.sv
// Shared constants and types for the free-running modulo counter.
// Holds default width, reset value, a count type and a max-value helper.
package counter_pkg;

    localparam int COUNTER_DEFAULT_WIDTH = 2;
    localparam int COUNTER_RST_VAL       = 0;

    // Count type at the default width; wider consumers declare
    // logic [W-1:0] against the same WIDTH parameter they pass down.
    typedef logic [COUNTER_DEFAULT_WIDTH-1:0] count_t;

    // Largest value representable in 'width' bits, saturating at 32 bits.
    function automatic int unsigned counter_max(input int width);
        if (width >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/counter_next.sv
// Next-state logic for the modulo counter: increment, or wrap to the
// reset value once the terminal value is reached. Purely combinational.
// Ports: i_count (current), i_max (terminal value), o_next (next count).
module counter_next
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic [WIDTH-1:0] i_max,
    output logic [WIDTH-1:0] o_next
);

    logic w_wrap;

    assign w_wrap = (i_count == i_max);

    always_comb begin
        o_next = i_count + WIDTH'(1);
        if (w_wrap) begin
            o_next = WIDTH'(COUNTER_RST_VAL);
        end
    end

endmodule

// File: rtl/counter_unit.sv
// Free-running modulo up-counter: 0..MAX_VAL then back to 0, every clk edge.
// Ports: clk, reset (async, active-low), count (registered output).
// Optional: define COUNTER_ASSERT_EN to compile in embedded assertions.
module counter_unit
    import counter_pkg::*;
#(
    parameter int          WIDTH   = COUNTER_DEFAULT_WIDTH,
    parameter int unsigned MAX_VAL = counter_max(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] LP_RST = WIDTH'(COUNTER_RST_VAL);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;

    counter_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .i_count (r_count),
        .i_max   (LP_MAX),
        .o_next  (w_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= LP_RST;
        end else begin
            r_count <= w_next;
        end
    end

    assign count = r_count;

`ifdef COUNTER_ASSERT_EN
    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "counter_unit: WIDTH must be >= 1");
    end

    if (WIDTH < 32 && MAX_VAL > counter_max(WIDTH)) begin : g_bad_max
        $fatal(1, "counter_unit: MAX_VAL exceeds 2**WIDTH-1");
    end

    // Held at zero while reset is low: checked on both clock phases
    // and at the moment reset is released.
    a_rst_clk : assert property (
        @(clk) !reset |-> (count == LP_RST)
    );

    a_rst_rel : assert property (
        @(posedge reset) (count == LP_RST)
    );

    a_range : assert property (
        @(posedge clk) (count <= LP_MAX)
    );

    // Edges straddling a reset release are excluded from the step check.
    a_step : assert property (
        @(posedge clk) disable iff (!reset)
        $past(reset) |->
            (count == (($past(count) == LP_MAX) ?
                       LP_RST : $past(count) + WIDTH'(1)))
    );
`else
    // Assertions compiled out; datapath identical.
`endif

endmodule

// File: tb/tb_counter_unit.sv
// Self-checking bench for counter_unit: vector table, async reset
// sequences and randomized reset activity against an edge-count model.
module tb_counter_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] cnt_d;
    logic [2:0] cnt_w3;
    logic [1:0] cnt_z;
    logic [3:0] cnt_r;

    counter_unit u_def (
        .clk   (clk),
        .reset (reset),
        .count (cnt_d)
    );

    counter_unit #(.WIDTH(3), .MAX_VAL(5)) u_w3 (
        .clk   (clk),
        .reset (reset),
        .count (cnt_w3)
    );

    counter_unit #(.WIDTH(2), .MAX_VAL(0)) u_z (
        .clk   (clk),
        .reset (reset),
        .count (cnt_z)
    );

    counter_unit #(.WIDTH(4), .MAX_VAL(9)) u_r (
        .clk   (clk),
        .reset (reset),
        .count (cnt_r)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic rst;
        int   e_d;
        int   e_w3;
        int   e_r;
    } vec_t;

    vec_t tbl[$];
    int   n;
    int   a;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: after release, count is the number of rising edges seen
    // with reset high, modulo (MAX_VAL+1).
    task automatic check_all(input string tag, input int edges);
        chk({tag, " def"}, 32'(cnt_d),  32'(edges % 4));
        chk({tag, " w3"},  32'(cnt_w3), 32'(edges % 6));
        chk({tag, " z"},   32'(cnt_z),  32'd0);
        chk({tag, " r"},   32'(cnt_r),  32'(edges % 10));
    endtask

    initial begin
        tbl.push_back('{1'b1, 1, 1, 1});
        tbl.push_back('{1'b1, 2, 2, 2});
        tbl.push_back('{1'b1, 3, 3, 3});
        tbl.push_back('{1'b1, 0, 4, 4});
        tbl.push_back('{1'b1, 1, 5, 5});
        tbl.push_back('{1'b1, 2, 0, 6});
        tbl.push_back('{1'b1, 3, 1, 7});
        tbl.push_back('{1'b1, 0, 2, 8});
        tbl.push_back('{1'b1, 1, 3, 9});
        tbl.push_back('{1'b1, 2, 4, 0});
        tbl.push_back('{1'b0, 0, 0, 0});
        tbl.push_back('{1'b0, 0, 0, 0});
        tbl.push_back('{1'b0, 0, 0, 0});
        tbl.push_back('{1'b0, 0, 0, 0});
        tbl.push_back('{1'b0, 0, 0, 0});
        tbl.push_back('{1'b1, 1, 1, 1});
        tbl.push_back('{1'b1, 2, 2, 2});

        reset = 1'b0;
        @(negedge clk);
        check_all("reset", 0);

        foreach (tbl[i]) begin
            reset = tbl[i].rst;
            @(negedge clk);
            chk($sformatf("vec%0d def", i), 32'(cnt_d), 32'(tbl[i].e_d));
            chk($sformatf("vec%0d w3", i), 32'(cnt_w3), 32'(tbl[i].e_w3));
            chk($sformatf("vec%0d z", i), 32'(cnt_z), 32'd0);
            chk($sformatf("vec%0d r", i), 32'(cnt_r), 32'(tbl[i].e_r));
        end

        // Mid-run async reset at count 2: must clear with no clock edge.
        reset = 1'b0;
        #1;
        check_all("async_mid", 0);
        @(negedge clk);
        check_all("async_hold", 0);
        reset = 1'b1;
        @(negedge clk);
        check_all("async_rel", 1);

        // Async reset landing just after a rising edge.
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_all("async_late", 0);
        @(negedge clk);
        reset = 1'b1;
        n = 0;

        for (int i = 0; i < 300; i++) begin
            a = int'($urandom_range(0, 15));
            if (reset == 1'b0) begin
                if (a < 8) reset = 1'b1;
            end else if (a == 0) begin
                reset = 1'b0;
                n = 0;
                #1;
                check_all("rand_neg", 0);
            end
            if (reset && a == 1) begin
                @(posedge clk);
                n++;
                #3;
                reset = 1'b0;
                n = 0;
                #1;
                check_all("rand_mid", 0);
            end else begin
                @(posedge clk);
                if (reset) n++;
            end
            @(negedge clk);
            check_all("rand", n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
